shape_motion_ctrl: RTL and testbench



---
 rtl/shape_motion_if.sv | 39 +++
 rtl/shape_motion_ctrl.sv | 169 ++++++++++++++++
 tb/tb_shape_motion_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/shape_motion_if.sv
// Bundle between the falling-piece controller and its environment (player inputs,
// renderer outputs, board lock handshake). Clock and reset stay outside.
interface shape_motion_if;
  logic       frame_tick;
  logic       start;
  logic [8:0] shape_in;
  logic       move_left;
  logic       move_right;
  logic       rotate;
  logic       soft_drop;
  logic       hard_drop;
  logic [9:0] x_shape;
  logic [9:0] y_shape;
  logic [8:0] blockNeighbors;
  logic       piece_active;
  // lock_valid/lock_ready: the landed piece (lock_col/lock_row/lock_mask) is offered
  // while lock_valid is high and stays stable until the cycle lock_valid & lock_ready,
  // which is the single transfer cycle; lock_valid never drops before that.
  logic       lock_valid;
  logic       lock_ready;
  logic [4:0] lock_col;
  logic [4:0] lock_row;
  logic [8:0] lock_mask;
  logic [2:0] state_dbg;

  modport master (
    input  frame_tick, start, shape_in, move_left, move_right, rotate,
           soft_drop, hard_drop, lock_ready,
    output x_shape, y_shape, blockNeighbors, piece_active,
           lock_valid, lock_col, lock_row, lock_mask, state_dbg
  );

  modport slave (
    output frame_tick, start, shape_in, move_left, move_right, rotate,
           soft_drop, hard_drop, lock_ready,
    input  x_shape, y_shape, blockNeighbors, piece_active,
           lock_valid, lock_col, lock_row, lock_mask, state_dbg
  );
endinterface

// File: rtl/shape_motion_ctrl.sv
// Falling 3x3 piece owner: gravity, left/right/rotate with bounds checks, lock handshake.
// Optional macro HARD_DROP_EN adds the DROPPING state driven by hard_drop.
module shape_motion_ctrl #(
  parameter int CELL        = 16,
  parameter int FIELD_X0    = 240,
  parameter int FIELD_Y0    = 80,
  parameter int FIELD_COLS  = 10,
  parameter int FIELD_ROWS  = 20,
  parameter int SPAWN_COL   = 4,
  parameter int DROP_FRAMES = 30,
  parameter int SOFT_FRAMES = 3
) (
  input logic           clk,
  input logic           rst,
  shape_motion_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPAWN    = 3'd1,
    ST_ACTIVE   = 3'd2,
    ST_LANDED   = 3'd3
`ifdef HARD_DROP_EN
    , ST_DROPPING = 3'd4
`endif
  } state_e;

  localparam int CW  = $clog2(DROP_FRAMES + 2);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] LIM_DROP = CW1'(DROP_FRAMES);
  localparam logic [CW:0] LIM_SOFT = CW1'(SOFT_FRAMES);
  localparam logic signed [6:0] COL_MAX = 7'(FIELD_COLS - 1);
  localparam logic signed [6:0] ROW_MAX = 7'(FIELD_ROWS - 1);

  state_e          st_q, st_d;
  logic [4:0]      col_q, col_d, row_q, row_d;
  logic [8:0]      mask_q, mask_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;

  logic signed [6:0] c_s, r_s;
  logic [CW:0]     lim, cnt_inc;
  logic            tick_hit, grav_due, pulse;

  // Every set cell of the mask must land inside the field; signed math keeps col-1 at 0 negative.
  function automatic logic fits(input logic signed [6:0] c, input logic signed [6:0] r,
                                input logic [8:0] m);
    logic              ok;
    logic signed [6:0] cc, rr;
    ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cc = c + $signed(7'(i / 3)) - 7'sd1;
      rr = r + $signed(7'(i % 3)) - 7'sd1;
      if (m[i] && ((cc < 7'sd0) || (cc > COL_MAX) || (rr < 7'sd0) || (rr > ROW_MAX)))
        ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [8:0] rot_cw(input logic [8:0] m);
    logic [8:0] n;
    n[6] = m[0]; n[3] = m[1]; n[0] = m[2];
    n[7] = m[3]; n[4] = m[4]; n[1] = m[5];
    n[8] = m[6]; n[5] = m[7]; n[2] = m[8];
    return n;
  endfunction

  assign c_s      = $signed({2'b00, col_q});
  assign r_s      = $signed({2'b00, row_q});
  assign lim      = bus.soft_drop ? LIM_SOFT : LIM_DROP;
  assign cnt_inc  = CW1'(cnt_q) + CW1'(1);
  assign tick_hit = bus.frame_tick && (cnt_inc >= lim);
  assign grav_due = pend_q || tick_hit;
`ifdef HARD_DROP_EN
  assign pulse    = bus.move_left | bus.move_right | bus.rotate | bus.hard_drop;
`else
  assign pulse    = bus.move_left | bus.move_right | bus.rotate;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      col_q  <= 5'(SPAWN_COL);
      row_q  <= 5'd1;
      mask_q <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      col_q  <= col_d;
      row_q  <= row_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    col_d  = col_q;
    row_d  = row_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    case (st_q)
      ST_IDLE: if (bus.start) st_d = ST_SPAWN;
      ST_SPAWN: begin
        mask_d = bus.shape_in;
        col_d  = 5'(SPAWN_COL);
        row_d  = 5'd1;
        cnt_d  = '0;
        pend_d = 1'b0;
        st_d   = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // One action per cycle; a blocked higher-priority request still consumes the cycle.
        if (bus.move_left) begin
          if (fits(c_s - 7'sd1, r_s, mask_q)) col_d = col_q - 5'd1;
        end else if (bus.move_right) begin
          if (fits(c_s + 7'sd1, r_s, mask_q)) col_d = col_q + 5'd1;
        end else if (bus.rotate) begin
          if (fits(c_s, r_s, rot_cw(mask_q))) mask_d = rot_cw(mask_q);
        end
`ifdef HARD_DROP_EN
        else if (bus.hard_drop) begin
          st_d = ST_DROPPING;
        end
`endif
        // A due step that collides with a pulse waits one cycle with the counter parked at terminal.
        if (grav_due) begin
          if (pulse) begin
            pend_d = 1'b1;
            if (!pend_q) cnt_d = cnt_inc[CW-1:0];
          end else begin
            pend_d = 1'b0;
            cnt_d  = '0;
            if (fits(c_s, r_s + 7'sd1, mask_q)) row_d = row_q + 5'd1;
            else                                st_d  = ST_LANDED;
          end
        end else if (bus.frame_tick) begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end
      ST_LANDED: if (bus.lock_ready) st_d = ST_SPAWN;
`ifdef HARD_DROP_EN
      ST_DROPPING: begin
        if (fits(c_s, r_s + 7'sd1, mask_q)) row_d = row_q + 5'd1;
        else                                st_d  = ST_LANDED;
      end
`endif
      default: st_d = ST_IDLE;
    endcase
  end

  assign bus.x_shape        = 10'(FIELD_X0 + int'(col_q) * CELL);
  assign bus.y_shape        = 10'(FIELD_Y0 + int'(row_q) * CELL);
  assign bus.blockNeighbors = mask_q;
`ifdef HARD_DROP_EN
  assign bus.piece_active   = (st_q == ST_ACTIVE) || (st_q == ST_DROPPING);
`else
  assign bus.piece_active   = (st_q == ST_ACTIVE);
`endif
  assign bus.lock_valid     = (st_q == ST_LANDED);
  assign bus.lock_col       = bus.lock_valid ? col_q  : '0;
  assign bus.lock_row       = bus.lock_valid ? row_q  : '0;
  assign bus.lock_mask      = bus.lock_valid ? mask_q : '0;
  assign bus.state_dbg      = st_q;

endmodule

// File: tb/tb_shape_motion_ctrl.sv
// Self-checking bench for shape_motion_ctrl: expected piece positions go into a queue as
// stimulus is driven and are popped against the renderer outputs after each clock.
module tb_shape_motion_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shape_motion_if bus();

  shape_motion_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [28:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_pos(input int col, input int row, input logic [8:0] m);
    exp_q.push_back({10'(240 + col * 16), 10'(80 + row * 16), m});
  endtask

  task automatic pop_check(input string tag);
    logic [28:0] e;
    e = '1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk({tag, "_x"},    32'(bus.x_shape),        32'(e[28:19]));
    chk({tag, "_y"},    32'(bus.y_shape),        32'(e[18:9]));
    chk({tag, "_mask"}, 32'(bus.blockNeighbors), 32'(e[8:0]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.frame_tick = 1'b0; bus.start = 1'b0; bus.shape_in = '0;
    bus.move_left = 1'b0; bus.move_right = 1'b0; bus.rotate = 1'b0;
    bus.soft_drop = 1'b0; bus.hard_drop = 1'b0; bus.lock_ready = 1'b0;
  endtask

  // One driven cycle: pulses high for a single clock, expectation queued before the edge.
  task automatic act(input logic ml, input logic mr, input logic rot, input logic tick,
                     input logic hd, input int col, input int row, input logic [8:0] m,
                     input string tag);
    bus.move_left = ml; bus.move_right = mr; bus.rotate = rot;
    bus.frame_tick = tick; bus.hard_drop = hd;
    expect_pos(col, row, m);
    step();
    bus.move_left = 1'b0; bus.move_right = 1'b0; bus.rotate = 1'b0;
    bus.frame_tick = 1'b0; bus.hard_drop = 1'b0;
    pop_check(tag);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    clr_inputs();
    rst = 1'b1;
    step();
    step();
    expect_pos(4, 1, 9'h000);
    pop_check("reset");
    chk("reset_active", 32'(bus.piece_active), 0);
    chk("reset_lvalid", 32'(bus.lock_valid), 0);
    chk("reset_lcol",   32'(bus.lock_col), 0);
    chk("reset_lrow",   32'(bus.lock_row), 0);
    chk("reset_lmask",  32'(bus.lock_mask), 0);
    chk("reset_state",  32'(bus.state_dbg), 0);
    rst = 1'b0;
    step();

    // Spawn: shape_in held through the SPAWN cycle.
    bus.start = 1'b1; bus.shape_in = 9'h09A;
    step();
    bus.start = 1'b0;
    expect_pos(4, 1, 9'h09A);
    step();
    pop_check("spawn");
    chk("spawn_active", 32'(bus.piece_active), 1);
    chk("spawn_state",  32'(bus.state_dbg), 2);

    act(1, 0, 0, 0, 0, 3, 1, 9'h09A, "ml1");
    act(1, 0, 0, 0, 0, 2, 1, 9'h09A, "ml2");
    act(1, 0, 0, 0, 0, 1, 1, 9'h09A, "ml3");
    act(1, 0, 0, 0, 0, 1, 1, 9'h09A, "ml4_wall");
    act(0, 0, 1, 0, 0, 1, 1, 9'h0B8, "rot1");
    act(1, 0, 0, 0, 0, 0, 1, 9'h0B8, "ml_col0");
    act(0, 0, 1, 0, 0, 0, 1, 9'h0B8, "rot_wall");
    act(0, 1, 0, 0, 0, 1, 1, 9'h0B8, "mr_col1");
    act(0, 0, 1, 0, 0, 1, 1, 9'h0B2, "rot2");
    act(0, 0, 1, 0, 0, 1, 1, 9'h03A, "rot3");
    act(0, 0, 1, 0, 0, 1, 1, 9'h09A, "rot4");
    act(1, 1, 0, 0, 0, 1, 1, 9'h09A, "prio_lr");
    act(0, 1, 1, 0, 0, 2, 1, 9'h09A, "prio_rrot");
    for (int c = 3; c <= 8; c++) act(0, 1, 0, 0, 0, c, 1, 9'h09A, "mr_run");
    act(0, 1, 0, 0, 0, 8, 1, 9'h09A, "mr_wall");

    // Gravity at DROP_FRAMES.
    ticks(29);
    expect_pos(8, 1, 9'h09A);
    pop_check("grav29");
    act(0, 0, 0, 1, 0, 8, 2, 9'h09A, "grav30");
    ticks(29);
    act(1, 0, 0, 1, 0, 7, 2, 9'h09A, "defer");
    act(0, 0, 0, 0, 0, 7, 3, 9'h09A, "defer_step");

    // Counter above the soft limit: step on the next tick.
    ticks(10);
    bus.soft_drop = 1'b1;
    act(0, 0, 0, 0, 0, 7, 3, 9'h09A, "soft_wait");
    act(0, 0, 0, 1, 0, 7, 4, 9'h09A, "soft_exceed");
    for (int r = 5; r <= 19; r++) begin
      ticks(2);
      act(0, 0, 0, 1, 0, 7, r, 9'h09A, "soft_run");
    end
    ticks(2);
    act(0, 0, 0, 1, 0, 7, 19, 9'h09A, "land");
    chk("land_lvalid", 32'(bus.lock_valid), 1);
    chk("land_lrow",   32'(bus.lock_row), 19);
    chk("land_lcol",   32'(bus.lock_col), 7);
    chk("land_lmask",  32'(bus.lock_mask), 32'h09A);
    chk("land_active", 32'(bus.piece_active), 0);
    chk("land_state",  32'(bus.state_dbg), 3);
    for (int i = 0; i < 5; i++) begin
      act(1, 0, 1, 1, 0, 7, 19, 9'h09A, "hold");
      chk("hold_lvalid", 32'(bus.lock_valid), 1);
      chk("hold_lrow",   32'(bus.lock_row), 19);
    end

    bus.soft_drop = 1'b0;
    bus.shape_in = 9'h0B8;
    bus.lock_ready = 1'b1;
    step();
    bus.lock_ready = 1'b0;
    chk("xfer_lvalid", 32'(bus.lock_valid), 0);
    chk("xfer_state",  32'(bus.state_dbg), 1);
    expect_pos(4, 1, 9'h0B8);
    step();
    pop_check("respawn");
    chk("respawn_active", 32'(bus.piece_active), 1);

`ifdef HARD_DROP_EN
    act(0, 0, 0, 0, 1, 4, 1, 9'h0B8, "hd_enter");
    chk("hd_state", 32'(bus.state_dbg), 4);
    for (int r = 2; r <= 18; r++) act(0, 1, 1, 0, 0, 4, r, 9'h0B8, "hd_run");
    step();
`else
    act(0, 0, 0, 0, 1, 4, 1, 9'h0B8, "hd_ignored");
    chk("hd_state", 32'(bus.state_dbg), 2);
    bus.soft_drop = 1'b1;
    for (int r = 2; r <= 18; r++) begin
      ticks(2);
      act(0, 0, 0, 1, 0, 4, r, 9'h0B8, "soft_run2");
    end
    ticks(2);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    bus.soft_drop = 1'b0;
`endif
    chk("land2_lvalid", 32'(bus.lock_valid), 1);
    chk("land2_lrow",   32'(bus.lock_row), 18);
    chk("land2_lcol",   32'(bus.lock_col), 4);
    chk("land2_lmask",  32'(bus.lock_mask), 32'h0B8);

    // Asynchronous reset while the piece is being offered.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_lvalid", 32'(bus.lock_valid), 0);
    chk("arst_mask",   32'(bus.blockNeighbors), 0);
    chk("arst_state",  32'(bus.state_dbg), 0);
    step();
    rst = 1'b0;
    bus.shape_in = 9'h09A;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_state",  32'(bus.state_dbg), 0);
      chk("idle_active", 32'(bus.piece_active), 0);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    expect_pos(4, 1, 9'h09A);
    step();
    pop_check("restart");
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
